full_seq: RTL and testbench

Run-level sequencer for the two-stage full network. It admits the tap-load stream, then meters sample vectors into the stage-0 data input under an in-flight credit limit. It counts completed output samples and signals completion. It sits between the testbench/host stream sources and the full network, and gates valid/ready only; data words pass beside it untouched.

---
 rtl/full_seq.sv | 149 ++++++++++++++
 tb/tb_full_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/full_seq.sv
// full_seq: run-level sequencer that loads taps, meters samples under a credit limit and signals completion
// Ports: clk/rst_n (async active-low); start/abort/num_samples control a run;
//   src_tap_* <-> tap_in_* gate the tap stream; src_data_* <-> st_data_* gate the sample stream;
//   st_data_out_vld/rdy are observed to count completed samples;
//   busy, load_done, done, err and inflight report progress.
// Optional watchdog: define FULL_SEQ_TIMEOUT_EN to enable it (adds the TMO_CYC parameter).
module full_seq #(
  parameter int TAPS = 16,
  parameter int VEC = 4,
  parameter int MAX_INFL = 2,
  parameter int CNT_W = 16
`ifdef FULL_SEQ_TIMEOUT_EN
  , parameter int TMO_CYC = 1024
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [CNT_W-1:0]          num_samples,
  input  logic                      src_tap_vld,
  output logic                      src_tap_rdy,
  output logic                      tap_in_vld,
  input  logic                      tap_in_rdy,
  output logic                      tap_in_fst,
  input  logic                      src_data_vld,
  output logic                      src_data_rdy,
  output logic                      st_data_vld,
  input  logic                      st_data_rdy,
  output logic                      st_data_fst,
  input  logic                      st_data_out_vld,
  input  logic                      st_data_out_rdy,
  output logic                      busy,
  output logic                      load_done,
  output logic                      done,
  output logic                      err,
  output logic [$clog2(MAX_INFL):0] inflight
);
  localparam int TW = $clog2(TAPS + 1);
  localparam int BW = VEC > 1 ? $clog2(VEC) : 1;
  localparam int IW = $clog2(MAX_INFL) + 1;
  localparam logic [TW-1:0] TAP_LAST = TW'(TAPS - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(VEC - 1);
  localparam logic [IW-1:0] INFL_MAX = IW'(MAX_INFL);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
  state_t state, nx;

  logic [CNT_W-1:0] num_r, issued, completed, issued_nx, completed_nx;
  logic [TW-1:0] tap_cnt;
  logic [BW-1:0] beat_cnt, obeat_cnt;
  logic acc_start, in_load, in_run, gate, tap_beat, tap_last, dbeat, issue;
  logic obeat, cmp, all_issued, all_done, tmo;

  // abort closes every gate in the cycle it is seen, so no beat slips past a frozen counter
  assign acc_start = (state == IDLE) & start & ~abort;
  assign in_load = (state == LOAD) & ~abort;
  assign in_run = (state == RUN) & ~abort;
  // credit is only checked at a sample boundary; a started sample always completes
  assign gate = in_run & ((beat_cnt != '0) | (inflight < INFL_MAX));

  assign tap_in_vld = in_load & src_tap_vld;
  assign src_tap_rdy = in_load & tap_in_rdy;
  assign tap_in_fst = in_load & (tap_cnt == '0);
  assign st_data_vld = gate & src_data_vld;
  assign src_data_rdy = gate & st_data_rdy;
  assign st_data_fst = in_run & (beat_cnt == '0);
  assign busy = state != IDLE;

  assign tap_beat = tap_in_vld & tap_in_rdy;
  assign tap_last = tap_beat & (tap_cnt == TAP_LAST);
  assign dbeat = st_data_vld & st_data_rdy;
  assign issue = dbeat & (beat_cnt == BEAT_LAST);
  assign obeat = ((state == RUN) | (state == DRAIN)) & ~abort & st_data_out_vld & st_data_out_rdy;
  assign cmp = obeat & (obeat_cnt == BEAT_LAST);
  assign issued_nx = issued + CNT_W'(issue);
  assign completed_nx = completed + CNT_W'(cmp);
  assign all_issued = issue & (issued_nx == num_r);
  // looks at the completion happening now so done follows the last output beat by one cycle
  assign all_done = completed_nx == num_r;

  always_comb begin
    nx = state;
    case (state)
      IDLE: nx = acc_start ? LOAD : IDLE;
      LOAD: nx = tap_last ? (num_r == '0 ? DRAIN : RUN) : LOAD;
      RUN: nx = all_issued ? DRAIN : RUN;
      DRAIN: nx = (all_done | tmo) ? DONE : DRAIN;
      default: nx = IDLE;
    endcase
    if (abort) nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      num_r <= '0;
      tap_cnt <= '0;
      beat_cnt <= '0;
      obeat_cnt <= '0;
      issued <= '0;
      completed <= '0;
      inflight <= '0;
      load_done <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nx;
      load_done <= tap_last;
      done <= (state == DRAIN) & (nx == DONE);
      if (acc_start) begin
        num_r <= num_samples;
        tap_cnt <= '0;
        beat_cnt <= '0;
        obeat_cnt <= '0;
        issued <= '0;
        completed <= '0;
        inflight <= '0;
      end else begin
        if (tap_beat) tap_cnt <= tap_last ? '0 : tap_cnt + TW'(1);
        if (dbeat) beat_cnt <= issue ? '0 : beat_cnt + BW'(1);
        if (obeat) obeat_cnt <= cmp ? '0 : obeat_cnt + BW'(1);
        issued <= issued_nx;
        completed <= completed_nx;
        inflight <= inflight + IW'(issue) - IW'(cmp);
      end
    end
  end

`ifdef FULL_SEQ_TIMEOUT_EN
  localparam int WW = $clog2(TMO_CYC + 1);
  logic [WW-1:0] wd;

  // wd holds the number of DRAIN cycles since the last output beat
  assign tmo = (state == DRAIN) & ~abort & ~obeat & ~all_done & (wd == WW'(TMO_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd <= '0;
      err <= 1'b0;
    end else begin
      wd <= state != DRAIN ? '0 : obeat ? WW'(1) : wd + WW'(1);
      err <= acc_start ? 1'b0 : err | tmo;
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_full_seq.sv
// tb_full_seq: directed, table-driven checks of the full_seq run sequencer
module tb_full_seq;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [15:0] num_samples = '0;
  logic tvld = 1'b0, trdy = 1'b0, dvld = 1'b0, drdy = 1'b0, ovld = 1'b0, ordy = 1'b0;
  logic src_tap_rdy, tap_in_vld, tap_in_fst, src_data_rdy, st_data_vld, st_data_fst;
  logic busy, load_done, done, err;
  logic [1:0] inflight;
  logic [11:0] act_v;
  int n_chk = 0, n_fail = 0, nbeats = 0, ndone = 0, nld = 0;
  int b0, b1, d0, l0;

  typedef struct {
    logic start, tvld, dvld, ovld;
    logic [11:0] exp;
  } vec_t;
  vec_t tbl [33];

  full_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_samples(num_samples),
    .src_tap_vld(tvld), .src_tap_rdy(src_tap_rdy), .tap_in_vld(tap_in_vld), .tap_in_rdy(trdy),
    .tap_in_fst(tap_in_fst), .src_data_vld(dvld), .src_data_rdy(src_data_rdy),
    .st_data_vld(st_data_vld), .st_data_rdy(drdy), .st_data_fst(st_data_fst),
    .st_data_out_vld(ovld), .st_data_out_rdy(ordy), .busy(busy), .load_done(load_done),
    .done(done), .err(err), .inflight(inflight)
  );

  always #5 clk = ~clk;

  assign act_v = {busy, tap_in_vld, src_tap_rdy, tap_in_fst, st_data_vld, src_data_rdy,
                  st_data_fst, load_done, done, err, inflight};

  always @(negedge clk) if (rst_n) begin
    nbeats += int'(st_data_vld & drdy);
    ndone += int'(done);
    nld += int'(load_done);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic go(input logic [15:0] n);
    start = 1'b1;
    num_samples = n;
    cyc(1);
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 33; i++) begin
      logic bz, tv, fs, dv, df, ld, dn;
      logic [1:0] inf;
      bz = i >= 1 && i <= 31;
      tv = i >= 1 && i <= 16;
      fs = i == 1;
      dv = i >= 17 && i <= 28;
      df = i == 17 || i == 21 || i == 25;
      ld = i == 17;
      dn = i == 31;
      inf = ((i >= 21 && i <= 22) || (i >= 25 && i <= 26) || (i >= 29 && i <= 30)) ? 2'd1 : 2'd0;
      tbl[i].start = i == 0;
      tbl[i].tvld = 1'b1;
      tbl[i].dvld = 1'b1;
      tbl[i].ovld = i >= 19 && i <= 30;
      tbl[i].exp = {bz, tv, tv, fs, dv, dv, df, ld, dn, 1'b0, inf};
    end
    cyc(2);
    rst_n = 1'b1;
    tvld = 1'b1; trdy = 1'b1; dvld = 1'b1; drdy = 1'b1; ovld = 1'b1; ordy = 1'b1;
    cyc(3);
    settle();
    chk("reset_idle", act_v, 0);
    cyc(1);
    num_samples = 16'd3;
    for (int i = 0; i < 33; i++) begin
      start = tbl[i].start;
      tvld = tbl[i].tvld;
      dvld = tbl[i].dvld;
      ovld = tbl[i].ovld;
      settle();
      chk($sformatf("vec%0d", i), act_v, tbl[i].exp);
      cyc(1);
    end

    // credit limit with a stalled output sink
    tvld = 1'b1; dvld = 1'b1; ovld = 1'b0;
    b0 = nbeats;
    go(3);
    cyc(32);
    settle();
    chk("credit_beats", nbeats - b0, 8);
    chk("credit_rdy", src_data_rdy, 0);
    chk("credit_infl", inflight, 2);
    cyc(1);
    dvld = 1'b0; ovld = 1'b1;
    cyc(4);
    ovld = 1'b0;
    settle();
    chk("release_infl", inflight, 1);
    b1 = nbeats;
    cyc(1);
    dvld = 1'b1;
    cyc(2);
    dvld = 1'b0;
    settle();
    chk("partial_beats", nbeats - b1, 2);
    chk("partial_fst", st_data_fst, 0);
    chk("partial_rdy", src_data_rdy, 1);
    cyc(1);
    dvld = 1'b1;
    cyc(10);
    settle();
    chk("third_beats", nbeats - b1, 4);
    chk("drain_infl", inflight, 2);
    chk("drain_busy", busy, 1);
    chk("drain_rdy", src_data_rdy, 0);
    d0 = ndone;
    cyc(1);
    ovld = 1'b1;
    cyc(8);
    ovld = 1'b0;
    cyc(2);
    settle();
    chk("credit_done", ndone - d0, 1);
    chk("credit_idle", busy, 0);
    chk("credit_infl0", inflight, 0);

    // zero-sample run goes straight through DRAIN
    cyc(1);
    b0 = nbeats; d0 = ndone;
    go(0);
    cyc(15);
    settle();
    chk("z_lasttap", tap_in_vld, 1);
    chk("z_done_early", done, 0);
    cyc(1);
    settle();
    chk("z_load_done", load_done, 1);
    chk("z_rdy", src_data_rdy, 0);
    cyc(1);
    settle();
    chk("z_done", done, 1);
    cyc(1);
    settle();
    chk("z_idle", busy, 0);
    chk("z_beats", nbeats - b0, 0);
    chk("z_done_cnt", ndone - d0, 1);

    // abort in RUN, then restart from scratch
    cyc(1);
    b0 = nbeats; d0 = ndone; l0 = nld;
    go(3);
    cyc(21);
    abort = 1'b1;
    settle();
    chk("abort_gate", st_data_vld, 0);
    chk("abort_beats", nbeats - b0, 5);
    cyc(1);
    abort = 1'b0;
    settle();
    chk("abort_idle", busy, 0);
    chk("abort_tap", tap_in_vld, 0);
    chk("abort_frozen", inflight, 1);
    cyc(3);
    settle();
    chk("abort_nodone", ndone - d0, 0);
    chk("abort_ld", nld - l0, 1);
    cyc(1);
    go(3);
    settle();
    chk("restart_fst", tap_in_fst, 1);
    chk("restart_infl", inflight, 0);
    cyc(16);
    settle();
    chk("restart_dfst", st_data_fst, 1);
    chk("restart_ld", load_done, 1);
    cyc(5);
    settle();
    chk("midrun_infl", inflight, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_infl", inflight, 0);
    chk("rst_gate", st_data_vld, 0);
    cyc(1);
    rst_n = 1'b1;

    // one sample withheld in DRAIN
    ovld = 1'b0;
    go(2);
    cyc(24);
    ovld = 1'b1;
    cyc(4);
    ovld = 1'b0;
    settle();
    chk("wd_busy", busy, 1);
    chk("wd_err0", err, 0);
    chk("wd_infl", inflight, 1);
    d0 = ndone;
    cyc(1022);
    settle();
    chk("wd_early", done, 0);
    cyc(1);
    settle();
`ifdef FULL_SEQ_TIMEOUT_EN
    chk("wd_done", done, 1);
    chk("wd_err", err, 1);
`else
    chk("wd_nodone", done, 0);
    chk("wd_wait", busy, 1);
`endif
    cyc(1);
    settle();
`ifdef FULL_SEQ_TIMEOUT_EN
    chk("wd_idle", busy, 0);
    chk("wd_sticky", err, 1);
    cyc(1);
    go(1);
    settle();
    chk("wd_clear", err, 0);
`else
    chk("wd_still", busy, 1);
    chk("wd_done_cnt", ndone - d0, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
